// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier: FSM states,
// Booth pair decode constants and the iteration counter width.
package booth_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadY,
        StCalc,
        StOutH,
        StOutL
    } state_e;

    // {Y[0], y_m1} pairs that require an add or a subtract of X
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Counter must hold the value W1 itself, not just W1-1
    function automatic int unsigned cnt_width(input int unsigned w1);
        return $clog2(w1 + 1);
    endfunction

endpackage

// File: rtl/booth_mult_step.sv
// One combinational radix-2 Booth iteration: add/sub X, then arithmetic right shift.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned W1 = 7
) (
    input  logic [W1-1:0] a,
    input  logic [W1-1:0] x,
    input  logic [W1-1:0] y,
    input  logic          y_m1,
    output logic [W1-1:0] a_nxt,
    output logic [W1-1:0] y_nxt,
    output logic          y_m1_nxt
);

    logic [W1-1:0] sum;

    always_comb begin
        sum = a;
        case ({y[0], y_m1})
            BOOTH_ADD: sum = a + x;
            BOOTH_SUB: sum = a - x;
            default:   sum = a;
        endcase
    end

    // Shift {sum, y, y_m1} right by one, replicating the accumulator sign bit
    assign a_nxt    = {sum[W1-1], sum[W1-1:1]};
    assign y_nxt    = {sum[0], y[W1-1:1]};
    assign y_m1_nxt = y[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with two-beat operand input, two-beat
// product output and valid/ready handshakes on both buses.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inBus,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_signed,
    output logic [WIDTH-1:0] outBus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned W1   = WIDTH + 1;
    localparam int unsigned CntW = cnt_width(W1);
    localparam logic [CntW-1:0] CntInit = CntW'(W1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e            state_q, state_d;
    logic [W1-1:0]     x_q, x_d;
    logic [W1-1:0]     a_q, a_d;
    logic [W1-1:0]     y_q, y_d;
    logic              ym1_q, ym1_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;

    logic [W1-1:0]     a_step, y_step;
    logic              ym1_step;
    logic [2*WIDTH-1:0] prod;

    // Sign- or zero-extend so unsigned operands survive the signed recoding
    function automatic logic [W1-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    booth_step #(
        .W1 (W1)
    ) u_step (
        .a        (a_q),
        .x        (x_q),
        .y        (y_q),
        .y_m1     (ym1_q),
        .a_nxt    (a_step),
        .y_nxt    (y_step),
        .y_m1_nxt (ym1_step)
    );

    // Top bits of {A,Y} are pure extension and are dropped
    assign prod = {a_q[WIDTH-2:0], y_q};
    assign busy = busy_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        a_d       = a_q;
        y_d       = y_q;
        ym1_d     = ym1_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        outBus    = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    x_d     = ext(inBus, mode_signed);
                    mode_d  = mode_signed;
                    busy_d  = 1'b1;
                    state_d = StLoadY;
                end
            end
            StLoadY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_d     = ext(inBus, mode_q);
                    a_d     = '0;
                    ym1_d   = 1'b0;
                    cnt_d   = CntInit;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                a_d   = a_step;
                y_d   = y_step;
                ym1_d = ym1_step;
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StOutH;
                end
            end
            StOutH: begin
                out_valid = 1'b1;
                outBus    = prod[2*WIDTH-1:WIDTH];
                if (out_ready) begin
                    state_d = StOutL;
                end
            end
            StOutL: begin
                out_valid = 1'b1;
                outBus    = prod[WIDTH-1:0];
                if (out_ready) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            a_q     <= '0;
            y_q     <= '0;
            ym1_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            y_q     <= y_d;
            ym1_q   <= ym1_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed corner cases plus random
// operands checked against a plain-arithmetic product model.
module tb_booth_mult_seq;

    localparam int W  = 6;
    localparam int W1 = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] inBus;
    logic         in_valid;
    logic         in_ready;
    logic         mode_signed;
    logic [W-1:0] outBus;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inBus       (inBus),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode_signed (mode_signed),
        .outBus      (outBus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ms);
        longint xs, ys;
        logic [63:0] p;
        xs = ms ? longint'($signed(x)) : longint'(x);
        ys = ms ? longint'($signed(y)) : longint'(y);
        p  = 64'(xs * ys);
        return p[2*W-1:0];
    endfunction

    // Monitor: every output beat transferred is popped and compared in order
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {63'b0, out_valid}, 64'd0);
            end else begin
                chk(name_q.pop_front(), 64'(outBus), 64'(exp_q.pop_front()));
            end
        end
    end

    // rst_at: CALC cycle index (0-based) at which to assert reset, -1 for none
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ms,
                         input bit junk, input int rst_at);
        logic [2*W-1:0] p;
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        inBus       = x;
        mode_signed = ms;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        mode_signed = ~ms;
        inBus       = y;
        @(posedge clk);
        #1;
        p = ref_prod(x, y, ms);
        exp_q.push_back(p[2*W-1:W]);
        name_q.push_back("beat_hi");
        exp_q.push_back(p[W-1:0]);
        name_q.push_back("beat_lo");
        in_valid = 1'b0;
        inBus    = W'($urandom);
        for (int i = 0; i < W1; i++) begin
            @(negedge clk);
            chk("calc_out_valid", 64'(out_valid), 64'd0);
            chk("calc_in_ready", 64'(in_ready), 64'd0);
            chk("calc_busy", 64'(busy), 64'd1);
            if (junk && i == 1) begin
                in_valid = 1'b1;
                inBus    = W'($urandom);
            end
            if (junk && i == 3) in_valid = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_outBus", 64'(outBus), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                exp_q.delete();
                name_q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("post_rst_in_ready", 64'(in_ready), 64'd1);
                return;
            end
        end
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [2*W-1:0] p;
        rst         = 1'b1;
        inBus       = '0;
        in_valid    = 1'b0;
        mode_signed = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outBus", 64'(outBus), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_in_ready", 64'(in_ready), 64'd1);

        // Directed corners
        do_op(6'h03, 6'h3E, 1'b1, 1'b0, -1);  wait_done();
        do_op(6'h20, 6'h20, 1'b1, 1'b1, -1);  wait_done();
        do_op(6'h3F, 6'h3F, 1'b0, 1'b0, -1);  wait_done();
        do_op(6'h3F, 6'h3F, 1'b1, 1'b0, -1);  wait_done();
        do_op(6'h00, 6'h00, 1'b1, 1'b0, -1);  wait_done();
        do_op(6'h00, 6'h2A, 1'b0, 1'b1, -1);  wait_done();

        // Backpressure in OUTH then a stall in OUTL
        out_ready = 1'b0;
        do_op(6'h03, 6'h3E, 1'b1, 1'b0, -1);
        p = ref_prod(6'h03, 6'h3E, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_outBus", 64'(outBus), 64'(p[2*W-1:W]));
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("bp_lo_outBus", 64'(outBus), 64'(p[W-1:0]));
            chk("bp_lo_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_lo_still_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("bp_busy_drop", 64'(busy), 64'd0);
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        wait_done();

        // Reset in the 3rd CALC cycle, then a fresh 5x5
        do_op(6'h11, 6'h2B, 1'b1, 1'b0, 2);
        do_op(6'h05, 6'h05, 1'b0, 1'b0, -1);  wait_done();

        // Random operands and modes
        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
